mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port data/instruction memory between the fetch unit (port 0) and the load/store unit (port 1). It accepts one request at a time through a req/gnt/rvalid handshake and drives the memory address, write-enable and write-data buses for exactly one cycle per access. It captures the memory read bus and returns the value to the winning requester. It sits between the core's fetch/LSU and the memory block, and is the only master on the memory buses.

## Interface
- DATA_W, 32, data bus width
- MEM_LEN, 64, number of memory words; ADDR_W = $clog2(MEM_LEN)
- ADDR_W, $clog2(MEM_LEN), address width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  request from port 0 (fetch) / port 1 (LSU)
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W+1  word address; the extra MSB allows out-of-range detection
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs latched
- rvalid0 / rvalid1  out  1  one-cycle pulse: response on rdata0 / rdata1
- rdata0 / rdata1  out  DATA_W  response data, held until the next response on that port
- err0 / err1  out  1  pulses with rvalid when the address was ≥ MEM_LEN
- mem_addr  out  ADDR_W  memory address bus
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid within the cycle mem_addr is driven

## Operation
- States:
  - IDLE
  - ISSUE: one access is driven on the memory buses.
  - RESP: the response cycle.
- IDLE: at a clock edge with any req high, pick a winner by the priority rule. Latch its we, addr and wdata, plus an out-of-range flag (addr ≥ MEM_LEN). Go to ISSUE. With no req, stay in IDLE.
- ISSUE:
  - gnt of the winner is high.
  - mem_addr is the latched addr[ADDR_W-1:0] and mem_wdata is the latched wdata.
  - mem_we = latched we AND NOT out-of-range.
  - At the ending edge, rdata of the winner captures mem_rdata, or 0 if out-of-range. Go to RESP.
- RESP:
  - rvalid of the winner is high, and err is high if the access was out-of-range.
  - Writes also return rvalid, with rdata = the value the memory reports at that address (the written data).
  - Arbitration runs exactly as in IDLE. A pending req goes directly to ISSUE; otherwise go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Drop req at the edge ending the gnt cycle, unless it issues a new request.
  - A req still high in RESP is treated as a new request.
- Priority: port 1 wins over port 0 when both request (fixed priority; see Configuration).
- Outside ISSUE: mem_we = 0, and mem_addr / mem_wdata hold their last values.
- rst (synchronous) forces IDLE from any state and abandons any in-flight access. The cycle after rst is sampled has mem_we = 0 and no gnt, rvalid or err.

## Timing
- Reset values:
  - gnt0/1, rvalid0/1, err0/1, mem_we = 0
  - rdata0/1, mem_addr, mem_wdata = 0
  - State = IDLE; round-robin pointer favours port 0.
- Latency: req sampled at edge N gives gnt in cycle N+1 (ISSUE) and rvalid/rdata in cycle N+2 (RESP).
- Throughput: one access per 2 cycles under continuous requests (ISSUE/RESP alternating).
- Strobes:
  - mem_we is high for exactly one cycle per accepted in-range write.
  - gnt and rvalid are single-cycle pulses, at most one port per cycle.
- A req arriving during ISSUE is not sampled until the RESP edge.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the port not granted most recently wins.
  - The pointer updates on every grant and resets to favour port 0.
  - A lone requester always wins.
- Not defined: fixed priority, port 1 over port 0. Port 0 can starve while port 1 requests continuously.

## Test plan
- Single read: after rst, req0=1, addr0=5, mem returns 0x5 → gnt0 in cycle N+1, mem_addr=5 and mem_we=0 during ISSUE, rvalid0 in N+2 with rdata0=0x5, err0=0.
- Write then read: req1 writes addr 10 with 0xDEADBEEF → mem_we high exactly one cycle; a following read of addr 10 on port 0 → rdata0=0xDEADBEEF.
- Simultaneous req0/req1 held for 4 grants:
  - Without MEM_ARB_RR_EN, the grant order is 1,1,1,1.
  - With it, the grant order is 0,1,0,1.
- Out-of-range: req0 write with addr0=64 → mem_we stays 0, rvalid0 with rdata0=0 and err0=1, memory contents unchanged.
- Back-to-back: port 1 re-requests in RESP → RESP goes straight to ISSUE, 2-cycle spacing between gnt1 pulses.
- Reset mid-operation: rst asserted during ISSUE of a write → next cycle IDLE, mem_we=0, no rvalid; all outputs at their reset values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response handshake for both ports plus the single-port memory bus.
// slave = arbiter side, master = requesters and memory side.
interface mem_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int MEM_LEN = 64
);
  localparam int ADDR_W = $clog2(MEM_LEN);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W:0]   addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0, err1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: IDLE -> ISSUE -> RESP.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 1 wins).
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LEN = 64
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int ADDR_W = $clog2(MEM_LEN);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              win_q;
  logic              last_q;
  logic              lat_we, lat_oor;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              any_req, accept, sel;
  logic [ADDR_W:0]   sel_addr;

  assign any_req  = bus.req0 | bus.req1;
  // A request is only sampled at edges leaving IDLE or RESP.
  assign accept   = (state_q != ISSUE) && any_req;
  assign sel_addr = sel ? bus.addr1 : bus.addr0;

  always_comb begin
    sel = 1'b0;
`ifdef MEM_ARB_RR_EN
    // last_q is the port granted most recently; the other one wins a tie.
    if (bus.req0 && bus.req1) sel = ~last_q;
    else                      sel = bus.req1;
`else
    sel = bus.req1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = any_req ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q     <= sel;
        last_q    <= sel;
        lat_we    <= sel ? bus.we1 : bus.we0;
        lat_oor   <= sel_addr >= LIMIT;
        lat_addr  <= sel_addr[ADDR_W-1:0];
        lat_wdata <= sel ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == ISSUE) begin
        if (win_q) rdata1_q <= lat_oor ? '0 : bus.mem_rdata;
        else       rdata0_q <= lat_oor ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.gnt0      = (state_q == ISSUE) && !win_q;
  assign bus.gnt1      = (state_q == ISSUE) &&  win_q;
  assign bus.rvalid0   = (state_q == RESP)  && !win_q;
  assign bus.rvalid1   = (state_q == RESP)  &&  win_q;
  assign bus.err0      = bus.rvalid0 && lat_oor;
  assign bus.err1      = bus.rvalid1 && lat_oor;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  // Latched buses hold their last value outside ISSUE; only the strobe is gated.
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.mem_we    = (state_q == ISSUE) && lat_we && !lat_oor;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus
// hand-written sequences for contention, back-to-back and reset mid-access.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(32), .MEM_LEN(64)) bus ();
  mem_arbiter #(.DATA_W(32), .MEM_LEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory model: read-through of the word being written so writes report new data.
  logic [31:0] mem [64];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_mwe;
  } vec_t;

  vec_t vt [8];

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_gnt"},    {bus.gnt0, bus.gnt1}, 2'b00);
    chk({nm, "_rvalid"}, {bus.rvalid0, bus.rvalid1}, 2'b00);
    chk({nm, "_err"},    {bus.err0, bus.err1}, 2'b00);
    chk({nm, "_mem_we"}, bus.mem_we, 1'b0);
  endtask

  // Issues one access and checks the ISSUE and RESP cycles; returns in RESP.
  task automatic run_txn(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    if (v.port) begin bus.req1 = 1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata; end
    else        begin bus.req0 = 1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata; end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_gnt"},      {bus.gnt1, bus.gnt0}, v.port ? 2'b10 : 2'b01);
    chk({tag, "_mem_addr"}, bus.mem_addr, v.addr[5:0]);
    chk({tag, "_mem_we"},   bus.mem_we, v.exp_mwe);
    chk({tag, "_early_rv"}, {bus.rvalid1, bus.rvalid0}, 2'b00);
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    chk({tag, "_rvalid"}, {bus.rvalid1, bus.rvalid0}, v.port ? 2'b10 : 2'b01);
    chk({tag, "_rdata"},  v.port ? bus.rdata1 : bus.rdata0, v.exp_rd);
    chk({tag, "_err"},    v.port ? bus.err1 : bus.err0, v.exp_err);
    chk({tag, "_we_off"}, bus.mem_we, 1'b0);
    chk({tag, "_gnt_off"}, {bus.gnt1, bus.gnt0}, 2'b00);
  endtask

  logic        order [4];
  logic        exp_order [4];
  int          n;
  int          gcyc [3];

  initial begin
    vt[0] = '{port:0, we:0, addr:7'd5,   wdata:32'h0,        exp_rd:32'h5,        exp_err:0, exp_mwe:0};
    vt[1] = '{port:1, we:1, addr:7'd10,  wdata:32'hDEADBEEF, exp_rd:32'hDEADBEEF, exp_err:0, exp_mwe:1};
    vt[2] = '{port:0, we:0, addr:7'd10,  wdata:32'h0,        exp_rd:32'hDEADBEEF, exp_err:0, exp_mwe:0};
    vt[3] = '{port:0, we:1, addr:7'd64,  wdata:32'h55555555, exp_rd:32'h0,        exp_err:1, exp_mwe:0};
    vt[4] = '{port:0, we:0, addr:7'd0,   wdata:32'h0,        exp_rd:32'h0,        exp_err:0, exp_mwe:0};
    vt[5] = '{port:1, we:0, addr:7'd63,  wdata:32'h0,        exp_rd:32'h3F,       exp_err:0, exp_mwe:0};
    vt[6] = '{port:1, we:1, addr:7'd127, wdata:32'h12345678, exp_rd:32'h0,        exp_err:1, exp_mwe:0};
    vt[7] = '{port:1, we:0, addr:7'd10,  wdata:32'h0,        exp_rd:32'hDEADBEEF, exp_err:0, exp_mwe:0};
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    idle_inputs();
    repeat (3) @(posedge clk);
    #1; rst = 0; mem_init = 0;
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_rdata",    {bus.rdata1, bus.rdata0}, 64'h0);
    chk("reset_mem_addr", bus.mem_addr, 6'd0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'h0);

    for (int i = 0; i < 8; i++) run_txn(i, vt[i]);
    chk("mem10_written", mem[10], 32'hDEADBEEF);
    chk("mem0_untouched", mem[0], 32'h0);

    // Contention: both ports hold req for four grants.
    @(posedge clk); #1;
    bus.req0 = 1; bus.addr0 = 7'd1; bus.req1 = 1; bus.addr1 = 7'd2;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge clk);
      chk("sim_onehot", bus.gnt0 & bus.gnt1, 1'b0);
      if (bus.gnt0) begin order[n] = 1'b0; n++; end
      else if (bus.gnt1) begin order[n] = 1'b1; n++; end
    end
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
    chk("sim_count", n, 4);
    for (int i = 0; i < 4; i++)
      if (i < n) chk($sformatf("sim_order%0d", i), order[i], exp_order[i]);

    // Back-to-back on port 1: req held through RESP keeps re-issuing.
    repeat (2) @(posedge clk); #1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'd3;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      @(negedge clk);
      if (bus.gnt1) begin gcyc[n] = cyc; n++; end
      if (bus.rvalid1) chk("b2b_rdata", bus.rdata1, 32'h3);
    end
    @(posedge clk); #1;
    bus.req1 = 0;
    chk("b2b_count", n, 3);
    if (n == 3) begin
      chk("b2b_gap0", gcyc[1] - gcyc[0], 2);
      chk("b2b_gap1", gcyc[2] - gcyc[1], 2);
    end

    // Reset during ISSUE of a write.
    repeat (2) @(posedge clk); #1;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 7'd20; bus.wdata1 = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_gnt", bus.gnt1, 1'b1);
    chk("rst_mid_we",  bus.mem_we, 1'b1);
    rst = 1; bus.req1 = 0; bus.we1 = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_quiet("rst_mid");
    chk("rst_mid_rdata", {bus.rdata1, bus.rdata0}, 64'h0);
    chk("rst_mid_mem_addr", bus.mem_addr, 6'd0);
    chk("rst_mid_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    chk_quiet("rst_after");

    run_txn(8, vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
